// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver/host side and the RX FIFO.
// The master drives the receiver word and the host read/clear strobes; the slave drives status and read data.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              rx_busy;
  logic [7:0]        uart_rx_data;
  logic              rd_en;
  logic              ovf_clr;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output rx_busy, uart_rx_data, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, overflow
  );

  modport slave (
    input  rx_busy, uart_rx_data, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Captures each byte completed by the UART receiver (falling edge of rx_busy)
// into a circular FIFO and serves it to the host through a registered read port.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_r;
  logic [7:0]        rd_data_r;
  logic              rd_valid_r, ovf_r, busy_d;
  logic              empty_w, full_w, byte_done, pop, push, drop;

  assign empty_w   = (count_r == '0);
  assign full_w    = (count_r == FULL_CNT);
  assign byte_done = busy_d & ~bus.rx_busy;
  assign pop       = bus.rd_en & ~empty_w;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push      = byte_done & (~full_w | pop);
  assign drop      = byte_done & full_w & ~pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_d     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      busy_d     <= bus.rx_busy;
      rd_valid_r <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_r <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      // A dropped byte outranks a clear arriving in the same cycle.
      if (drop)             ovf_r <= 1'b1;
      else if (bus.ovf_clr) ovf_r <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.uart_rx_data;
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.empty    = empty_w;
  assign bus.full     = full_w;
  assign bus.count    = count_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a table of hand-derived vectors plus scripted sequences
// checked against a queue model of the FIFO and a read-data scoreboard.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.ADDR_W(4)) bus ();
  uart_rx_fifo #(.ADDR_W(4), .DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       busy;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [4:0] cnt;
    logic       vld;
    logic [7:0] rdat;
    logic       ovf;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] mq[$];   // model FIFO contents
  logic [7:0] sb[$];   // expected read data, in order
  logic       m_busy_d = 1'b0;
  logic       m_ovf = 1'b0;
  logic [7:0] last_rd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one cycle (called at a negedge), update the model, check at the next negedge.
  task automatic cycle(input logic busy, input logic [7:0] d, input logic rd, input logic clr);
    logic bd, full_m, pop_m;
    logic [7:0] e;
    bus.rx_busy = busy; bus.uart_rx_data = d; bus.rd_en = rd; bus.ovf_clr = clr;
    bd     = m_busy_d & ~busy;
    full_m = (mq.size() == 16);
    pop_m  = rd && (mq.size() != 0);
    if (pop_m) begin e = mq.pop_front(); sb.push_back(e); end
    if (bd && (!full_m || pop_m)) mq.push_back(d);
    if (bd && full_m && !pop_m) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_busy_d = busy;
    @(negedge clk);
    chk("rd_valid", 32'(bus.rd_valid), 32'(pop_m));
    if (bus.rd_valid) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else last_rd = sb.pop_front();
    end
    chk("rd_data", 32'(bus.rd_data), 32'(last_rd));
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("full", 32'(bus.full), 32'(mq.size() == 16));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic push_byte(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
    cycle(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic read1();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    bus.rx_busy = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rdata", 32'(bus.rd_data), 32'h00);
    mq.delete(); sb.delete();
    m_busy_d = 1'b0; m_ovf = 1'b0; last_rd = 8'h00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic vec_t mk(input logic b, input logic [7:0] d, input logic r,
                              input logic [4:0] c, input logic v, input logic [7:0] rd_d);
    vec_t t;
    t.busy = b; t.data = d; t.rd = r; t.clr = 1'b0;
    t.cnt = c; t.vld = v; t.rdat = rd_d; t.ovf = 1'b0;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    // Empty corner: rd_en with nothing stored, then a push under rd_en.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b1, 8'h3C, 1'b1, 5'd0, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 8'h3C, 1'b1, 5'd1, 1'b0, 8'h00));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'h3C));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h3C));
    // Single byte: ten busy cycles then the falling edge.
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1'b1, 8'hA5, 1'b0, 5'd0, 1'b0, 8'h3C));
    tbl.push_back(mk(1'b0, 8'hA5, 1'b0, 5'd1, 1'b0, 8'h3C));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 8'hA5));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5));

    bus.rx_busy = 1'b0; bus.uart_rx_data = 8'h00; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].busy, tbl[i].data, tbl[i].rd, tbl[i].clr);
      chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].cnt == 5'd0));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.rd_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_rdata", i), 32'(bus.rd_data), 32'(tbl[i].rdat));
      chk($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
    end

    // Fill and overflow, drain 11, leaving 5 stored with overflow set.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_count", 32'(bus.count), 32'd16);
    push_byte(8'hFF);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 11; i++) read1();
    chk("pre_rst_count", 32'(bus.count), 32'd5);

    // Reset mid-operation with a byte in flight.
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    do_reset();
    cycle(1'b0, 8'h99, 1'b0, 1'b0);
    chk("inflight_dropped", 32'(bus.count), 32'd0);
    push_byte(8'h7E);
    read1();
    chk("first_after_rst", 32'(bus.rd_data), 32'h7E);

    // Wrap-around past the last slot.
    for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i));
    for (int i = 0; i < 10; i++) read1();
    for (int i = 0; i < 10; i++) push_byte(8'h20 + 8'(i));
    for (int i = 0; i < 10; i++) read1();
    chk("wrap_last", 32'(bus.rd_data), 32'h29);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 8'h55, 1'b1, 1'b0);
    chk("sim_rdata", 32'(bus.rd_data), 32'h00);
    chk("sim_count", 32'(bus.count), 32'd16);
    chk("sim_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) read1();
    chk("sim_last", 32'(bus.rd_data), 32'h55);

    // Overflow clear racing a drop, then a plain clear.
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b0, 8'hEE, 1'b0, 1'b1);
    chk("clr_vs_set", 32'(bus.overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_only", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) read1();
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
